// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Bus between the eight requesters (and the mux data they own) and the
// round-robin arbiter that drives the 8:1 mux select.
//
// Signals:
//   req[7:0]  requester -> arbiter : level request, bit i = requester i
//   A[7:0]    requester -> arbiter : mux data inputs, bit i owned by i
//   Sel[2:0]  arbiter -> requester : registered select (current/last owner)
//   gnt[7:0]  arbiter -> requester : registered one-hot grant, 0 when idle
//   F         arbiter -> requester : registered A[Sel] sample
//   F_valid   arbiter -> requester : F was sampled under an active grant
//   busy      arbiter -> requester : arbiter is in GRANT state
//
// Handshake: req[i] is a level that must stay high for as long as requester i
// wants the mux; ownership exists exactly while gnt[i] is high, and the owner
// releases by dropping req[i] (or loses the grant at tenure expiry). F is
// qualified by F_valid; there is no back-pressure on F.
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] A;
    logic [2:0] Sel;
    logic [7:0] gnt;
    logic       F;
    logic       F_valid;
    logic       busy;

    modport master (
        output req, A,
        input  Sel, gnt, F, F_valid, busy
    );

    modport slave (
        input  req, A,
        output Sel, gnt, F, F_valid, busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter / sequencer for a shared 8:1 single-bit mux. Grants one
// requester at a time, drives the mux select, bounds each grant to
// HOLD_CYCLES cycles and registers the selected data bit with a valid flag.
//
// Parameters:
//   HOLD_CYCLES   maximum consecutive grant cycles per owner (1..16)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   bus           mux8_rr_arbiter_if.slave (req, A in; Sel, gnt, F, F_valid,
//                 busy out)
//   dbg_state_o   FSM state (0 = IDLE, 1 = GRANT)
//   dbg_cnt_o     remaining tenure counter
//   dbg_last_o    last-owner round-robin pointer
//
// Configuration macro:
//   MUX8_ARB_FIXED_PRIO_EN  when defined, lowest asserted index always wins
//                           and the round-robin pointer is ignored.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus,
    output logic [0:0]         dbg_state_o,
    output logic [3:0]         dbg_cnt_o,
    output logic [2:0]         dbg_last_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic [7:0] gnt_q,   gnt_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] last_q,  last_d;
    logic       f_q,     f_d;
    logic       f_valid_q, f_valid_d;

    logic [3:0] idle_pick;   // {found, index}
    logic [3:0] rel_pick;    // {found, index}
    logic       release_c;

    // Scan r starting at index 'start', wrapping modulo 8; first set bit wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] w;
        found = 1'b0;
        w     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return {found, w};
    endfunction

    always_comb begin
`ifdef MUX8_ARB_FIXED_PRIO_EN
        // Fixed priority: the owner is not masked, so an expired owner that
        // is still the lowest requester simply wins again.
        idle_pick = rr_pick(bus.req, 3'd0);
        rel_pick  = rr_pick(bus.req, 3'd0);
`else
        idle_pick = rr_pick(bus.req, last_q + 3'd1);
        // On release the owner is masked so any other requester goes first.
        rel_pick  = rr_pick(bus.req & ~(8'd1 << sel_q), sel_q + 3'd1);
`endif
        // Owner drop and tenure expiry together still form one release.
        release_c = !bus.req[sel_q] || (cnt_q == 4'd0);

        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        f_d       = bus.A[sel_q];
        f_valid_d = (state_q == ST_GRANT);

        case (state_q)
            ST_IDLE: begin
                if (idle_pick[3]) begin
                    state_d = ST_GRANT;
                    sel_d   = idle_pick[2:0];
                    gnt_d   = 8'd1 << idle_pick[2:0];
                    cnt_d   = CNT_LOAD;
                    last_d  = idle_pick[2:0];
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    if (rel_pick[3]) begin
                        // Back-to-back handover on the release edge.
                        sel_d  = rel_pick[2:0];
                        gnt_d  = 8'd1 << rel_pick[2:0];
                        cnt_d  = CNT_LOAD;
                        last_d = rel_pick[2:0];
                    end else if (bus.req[sel_q]) begin
                        // Tenure expired with no contenders: keep the owner.
                        cnt_d = CNT_LOAD;
                    end else begin
                        // Nobody left; Sel keeps pointing at the last owner.
                        state_d = ST_IDLE;
                        gnt_d   = 8'd0;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            gnt_q     <= 8'd0;
            cnt_q     <= 4'd0;
            last_q    <= 3'd7;
            f_q       <= 1'b0;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
        end
    end

    assign bus.Sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.F       = f_q;
    assign bus.F_valid = f_valid_q;
    assign bus.busy    = (state_q == ST_GRANT);

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;
    assign dbg_last_o  = last_q;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8:1 single-bit selection mux. Eight requesters compete for the mux; the block grants one at a time, drives the 3-bit select, enforces a bounded grant tenure, and registers the selected data bit with a valid flag. It sits directly in front of the 8:1 mux datapath and is its only source of `Sel`.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles one requester may hold the grant; legal range 1..16.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `req` input 8: request vector; bit i = requester i wants the mux.
- `A` input 8: mux data inputs; bit i belongs to requester i.
- `Sel` output 3: registered select, index of current or most recent owner.
- `gnt` output 8: registered one-hot grant; all-zero when idle.
- `F` output 1: registered `A[Sel]` sample.
- `F_valid` output 1: high when `F` was sampled under an active grant.
- `busy` output 1: high in GRANT state.

## Operation
- States: IDLE (no owner), GRANT (owner o = `Sel`, tenure counter `cnt`).
- Reset values: state IDLE, `gnt`=0, `Sel`=0, `F`=0, `F_valid`=0, `busy`=0, `cnt`=0, last-owner pointer `last`=7, so the first search starts at requester 0.
- Round-robin pick: scan indices `last+1`, `last+2`, ... modulo 8; first asserted `req` bit wins.
- IDLE: if `req`≠0, pick winner w, go GRANT, `Sel`=w, `gnt`=1<<w, `cnt`=HOLD_CYCLES-1, `last`=w. Else stay IDLE.
- GRANT, release condition: `req[o]`=0 or `cnt`=0. Otherwise `cnt` decrements and the grant holds.
- On release: pick from `req` with bit o masked, starting at o+1. If a winner exists, grant it on the same edge (back-to-back, no idle cycle). If none exists but `req[o]`=1 (tenure expired, no contenders), re-grant o with `cnt` reloaded. If none at all, go IDLE, `gnt`=0, `Sel` keeps its value.
- `F` is updated every cycle with `A[Sel]` using the current registered `Sel`; `F_valid` = `busy` of the same cycle, registered.
- HOLD_CYCLES=1: `cnt` is always 0, so ownership rotates every cycle among active requesters.
- `req` changes outside the owner bit never pre-empt a grant before release.

## Timing
- Request-to-grant latency: 1 cycle from an IDLE cycle with `req` sampled high.
- Handover: 0 idle cycles; new `gnt`/`Sel` on the edge at which the release condition is sampled.
- Maximum tenure: HOLD_CYCLES cycles of `gnt` high per grant.
- `F`/`F_valid` lag `Sel`/`busy` by exactly 1 cycle.
- Worst-case wait for a continuously requesting port: 7 × HOLD_CYCLES cycles.
- Reset mid-grant: on the edge with `rst_n`=0, all outputs take reset values; the pointer returns to 7.
- Simultaneous owner drop and tenure expiry: a single release, not two.

## Configuration
- `MUX8_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index asserted request always wins, `last` is ignored, and tenure expiry still forces re-arbitration, so a lower index can take over.
- Undefined (default): round-robin as above.

## Test plan
- Reset then `req`=8'h00 for 5 cycles -> `gnt`=0, `busy`=0, `F_valid`=0, `Sel`=0 throughout.
- `req`=8'h01, `A`=8'h01, HOLD_CYCLES=4 -> `gnt`=8'h01 next cycle, held 4 cycles, then re-granted to 0; `F`=1 and `F_valid`=1 from one cycle after grant.
- `req`=8'h81 held, HOLD_CYCLES=4 -> grants alternate 0 then 7, 4 cycles each, no gap; `Sel` is 0,0,0,0,7,7,7,7,0...
- Owner 2 drops `req` after 2 cycles while `req[5]`=1 -> `gnt`=8'h20 on the release edge, `Sel`=5, `cnt`=3.
- `rst_n`=0 for one cycle mid-grant of owner 6 -> next cycle all outputs at reset; with `req`=8'hFF the next grant goes to 0.
- With `MUX8_ARB_FIXED_PRIO_EN` and `req`=8'hFF -> after each 4-cycle tenure, port 0 is re-granted; no other port is ever granted.
